// File: rtl/load_store_unit.sv
// load_store_unit: memory-access initiator between the execute stage and the word-wide memory.
// Accepts one load or store at a time; sub-word stores are done as read-modify-write.
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   req_i / ready_o        request handshake; req_i sampled only while ready_o = 1
//   store_i, size_i,       request kind (size 00 byte, 01 half, 10/11 word), sign extension
//   sign_i, addr_i,        byte address, store data (sub-word data in the LSBs)
//   wdata_i
//   rdata_o                load result, valid with done_o and held afterwards
//   done_o, fault_o        one-cycle completion pulse; fault_o marks a rejected request
//   mem_address_o,         word-aligned memory address, write data and write enable
//   mem_data_in_o,
//   mem_write_o
//   mem_data_out_i         synchronous read data (valid the cycle after the address)
module load_store_unit #(
    parameter int unsigned rom_end = 64000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        ready_o,
    input  logic        store_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        fault_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_data_in_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_data_out_i
);

    localparam logic [31:0] RomEnd = 32'(rom_end);

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapture,
        StWrite,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    logic        store_q, store_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        done_q, done_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_address_q, mem_address_d;
    logic [31:0] mem_data_in_q, mem_data_in_d;

    logic        req_fault;

    // Load extraction: sub-word lanes are extended, full words are rotated right by the
    // byte offset (ARM unaligned-load behaviour).
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [1:0] sz, input logic sg);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] rot;
        logic [31:0] res;
        unique case (lane)
            2'd0: begin b = w[7:0];   rot = w;                    end
            2'd1: begin b = w[15:8];  rot = {w[7:0], w[31:8]};   end
            2'd2: begin b = w[23:16]; rot = {w[15:0], w[31:16]}; end
            default: begin b = w[31:24]; rot = {w[23:0], w[31:24]}; end
        endcase
        h = lane[1] ? w[31:16] : w[15:0];
        if (sz == 2'b00) begin
            res = {{24{sg & b[7]}}, b};
        end else if (sz == 2'b01) begin
            res = {{16{sg & h[15]}}, h};
        end else begin
            res = rot;
        end
        return res;
    endfunction

    // Store merge for byte/halfword: replace the addressed lane of the fetched word.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] lane,
                                          input logic [1:0] sz, input logic [15:0] d);
        logic [31:0] res;
        res = w;
        if (sz == 2'b00) begin
            unique case (lane)
                2'd0: res[7:0]   = d[7:0];
                2'd1: res[15:8]  = d[7:0];
                2'd2: res[23:16] = d[7:0];
                default: res[31:24] = d[7:0];
            endcase
        end else if (lane[1]) begin
            res[31:16] = d;
        end else begin
            res[15:0] = d;
        end
        return res;
    endfunction

    // ROM stores and misaligned halfwords are rejected without touching memory.
    assign req_fault = (store_i && (addr_i < RomEnd)) || ((size_i == 2'b01) && addr_i[0]);

    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        store_d       = store_q;
        size_d        = size_q;
        sign_d        = sign_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        fault_d       = fault_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;

        unique case (state_q)
            StIdle: begin
                if (req_i) begin
                    lane_d  = addr_i[1:0];
                    store_d = store_i;
                    size_d  = size_i;
                    sign_d  = sign_i;
                    wdata_d = wdata_i[15:0];
                    if (req_fault) begin
                        fault_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        mem_address_d = {addr_i[31:2], 2'b00};
                        if (store_i && size_i[1]) begin
                            // Full-word store needs no read; size 11 behaves as word.
                            mem_data_in_d = wdata_i;
                            state_d       = StWrite;
                        end else begin
                            state_d = StRead;
                        end
                    end
                end
            end
            StRead: begin
                state_d = StCapture;
            end
            StCapture: begin
                if (store_q) begin
                    mem_data_in_d = merge(mem_data_out_i, lane_q, size_q, wdata_q);
                    state_d       = StWrite;
                end else begin
                    rdata_d = extract(mem_data_out_i, lane_q, size_q, sign_q);
                    state_d = StDone;
                end
            end
            StWrite: begin
                state_d = StDone;
            end
            StDone: begin
                fault_d = 1'b0;
                state_d = StIdle;
            end
            default: begin
                fault_d = 1'b0;
                state_d = StIdle;
            end
        endcase

        done_d      = (state_d == StDone);
        mem_write_d = (state_d == StWrite);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            lane_q        <= 2'b00;
            store_q       <= 1'b0;
            size_q        <= 2'b00;
            sign_q        <= 1'b0;
            wdata_q       <= 16'h0000;
            rdata_q       <= 32'h0000_0000;
            fault_q       <= 1'b0;
            done_q        <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= 32'h0000_0000;
            mem_data_in_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            store_q       <= store_d;
            size_q        <= size_d;
            sign_q        <= sign_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            fault_q       <= fault_d;
            done_q        <= done_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    assign ready_o       = (state_q == StIdle);
    assign rdata_o       = rdata_q;
    assign done_o        = done_q;
    assign fault_o       = fault_q;
    assign mem_address_o = mem_address_q;
    assign mem_data_in_o = mem_data_in_q;
    assign mem_write_o   = mem_write_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator sitting between the ARM core's execute stage and the `memory` block (ROM below `rom_end`, RW above). It accepts one load or store request at a time and drives the word-wide memory port: address, write data and write strobe. Byte and halfword stores are done as read-modify-write. Load data is extracted with sign or zero extension, or with ARM rotation for unaligned word loads, and returned with a one-cycle `done` pulse.

## Interface
Parameters:
- `rom_end`, default 64000: first RW byte address; any store below it faults.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  request; sampled only when `ready`=1.
- `ready`  out  1  unit idle, can accept `req`.
- `store`  in  1  1=store, 0=load.
- `size`  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
- `sign`  in  1  sign-extend sub-word loads.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data; sub-word data is taken from the LSBs.
- `rdata`  out  32  load result; valid while `done`=1, held afterwards.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  qualifies `done`: request rejected, no memory write.
- `mem_address`  out  32  to memory `address`; always word-aligned.
- `mem_data_in`  out  32  to memory `data_in`.
- `mem_write`  out  1  to memory `write`.
- `mem_data_out`  in  32  from memory `data_out`.

## Operation
- Memory model: synchronous read, so `mem_data_out` is valid the cycle after `mem_address` is presented. A write is captured on the rising edge where `mem_write`=1. `mem_address` stays stable from presentation through capture, because the ROM/RW select in the memory block decodes the current address.
- States:
  - IDLE: `ready`=1.
  - READ: address presented.
  - CAPTURE: `mem_data_out` is latched, then extracted (load) or merged (store).
  - WRITE: `mem_write`=1.
  - DONE: `done`=1.
- Transitions from IDLE on `req`:
  - `addr`, `store`, `size`, `sign` and `wdata` are latched at that edge.
  - Fault (store with `addr` < `rom_end`, or halfword with `addr[0]`=1) goes to DONE with `fault`=1.
  - Word store goes to WRITE.
  - Otherwise the unit goes to READ.
- Transitions from the other states:
  - READ goes to CAPTURE.
  - CAPTURE goes to DONE for a load, or to WRITE for a store.
  - WRITE goes to DONE.
  - DONE goes to IDLE.
- `req` is ignored outside IDLE. Back-to-back requests are therefore spaced by at least one IDLE cycle.
- Load extraction (little-endian, lane = `addr[1:0]`):
  - Byte: `word[8*lane+7:8*lane]`.
  - Halfword: lane `addr[1]`.
  - Sub-word loads are zero- or sign-extended to 32 bits according to `sign`.
  - Word: the fetched word rotated right by `8*addr[1:0]`.
- Store merge:
  - Byte/halfword: the fetched word with the addressed lane replaced by `wdata[7:0]` or `wdata[15:0]`.
  - Word: `wdata` as is; `addr[1:0]` is ignored and `mem_address` = {`addr[31:2]`,00}.
- Faulted requests never assert `mem_write` and never issue a read. On a fault, `rdata` keeps its previous value.

## Timing
- Cycle 0 is the IDLE cycle in which `req`=1 is sampled.
- `done` cycle by request type:
  - Fault: cycle 1.
  - Word store: cycle 2, with `mem_write` in cycle 1.
  - Load: cycle 3.
  - Sub-word store: cycle 4, with `mem_write` in cycle 3.
- `ready` is 0 from cycle 1 up to and including the DONE cycle.
- `mem_address` is registered; it holds its last value outside active states.
- `mem_write` is registered; it is high exactly one cycle per non-faulted store.
- Reset values:
  - State IDLE, `ready`=1.
  - `done`=0, `fault`=0, `mem_write`=0.
  - `rdata`=0, `mem_address`=0, `mem_data_in`=0.
- Reset mid-operation: all outputs go to reset values immediately and asynchronously, including `mem_write` dropping during WRITE. The in-flight request is discarded with no `done`. The first `req` after release is handled normally.

## Test plan
- Signed byte load: word 0x80FF7F01 at 0x00010000; load byte at 0x00010003 with `sign`=1. Required: `rdata`=0xFFFFFF80, `done` in cycle 3. Repeat with `sign`=0: `rdata`=0x00000080.
- Halfword store: word 0x11223344 at 0x00010000; store halfword 0xBEEF at 0x00010002. Required: `mem_write` high only in cycle 3 with `mem_data_in`=0xBEEF3344; `done` in cycle 4; a readback gives 0xBEEF3344.
- Unaligned word load at 0x00010001 with word 0x11223344. Required: `rdata`=0x44112233. Word store 0xCAFEF00D at 0x00010006. Required: `mem_address`=0x00010004, `mem_write` in cycle 1, `done` in cycle 2.
- ROM store to 0x00000100. Required: `done`+`fault` in cycle 1, `mem_write` never 1, `ready` back to 1 in cycle 2. Halfword load at 0x00010001. Required: `fault`=1.
- `req` held high for 10 cycles with loads. Required: each request completes in 3 cycles and is followed by one IDLE cycle before the next is accepted. Changing `addr` mid-operation does not affect the result.
- Reset asserted during WRITE. Required: `mem_write` drops immediately, no `done`, `ready`=1. After release a word load returns correct data in 3 cycles.
